mem_bus_ctrl: RTL and testbench

//  Memory-side stage directly downstream of the CPU: consumes mem_cmd/mem_addr/write_data
//  and returns read_data plus a one-cycle mem_rdy completion strobe.

---
 rtl/mem_bus_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-side stage behind the CPU.
// Serves READ/WRITE commands from a single-port synchronous RAM, with optional
// memory-mapped LED/switch registers and a fixed number of wait states per access.
// Every accepted command (including illegal/unmapped ones) completes with a
// one-cycle mem_rdy pulse, 2+WAIT_STATES cycles after the command was sampled.
// Optional feature: define MEM_BUS_MMIO_EN to decode LED (0x100) and SW (0x140).
module mem_bus_ctrl #(
    parameter int    ADDR_W      = 9,
    parameter int    DATA_W      = 16,
    parameter int    RAM_DEPTH   = 256,
    parameter int    WAIT_STATES = 0,          // 0..15 idle cycles before each access
    parameter string INIT_FILE   = "data.txt"  // RAM image name handed to the implementation flow
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_rdy,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);

    localparam int                IDX_W     = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W:0]   RAM_TOP   = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [1:0]        CMD_NONE  = 2'b00;
    localparam logic [1:0]        CMD_READ  = 2'b01;
    localparam logic [1:0]        CMD_WRITE = 2'b10;
    // Counter preload: the WAIT state is occupied for exactly WAIT_STATES cycles.
    localparam logic [3:0]        WCNT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e              state_q;
    logic [3:0]          wcnt_q;
    logic [1:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rdata_d;
    logic                rdy_q;
    logic                is_ram;
    logic [IDX_W-1:0]    ram_idx;

    // RAM contents are deliberately not reset.
    logic [DATA_W-1:0]   mem_q [RAM_DEPTH];

`ifdef MEM_BUS_MMIO_EN
    localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'('h100);
    localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'('h140);

    logic [7:0] led_q;
    logic [7:0] sw_meta_q;
    logic [7:0] sw_sync_q;
    logic       is_led;
    logic       is_sw;

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign is_led  = (addr_q == LED_ADDR);
    assign is_sw   = (addr_q == SW_ADDR);
    assign led_out = led_q;
`else
    logic unused_sw;
    assign unused_sw = ^sw_in;
    assign led_out   = '0;
`endif

    assign is_ram    = ({1'b0, addr_q} < RAM_TOP);
    assign ram_idx   = addr_q[IDX_W-1:0];
    assign read_data = rdata_q;
    assign mem_rdy   = rdy_q;

    // Read-return mux on the latched command/address; anything not a mapped read yields zero.
    always_comb begin
        rdata_d = '0;
        if (cmd_q == CMD_READ) begin
            if (is_ram) begin
                rdata_d = mem_q[ram_idx];
`ifdef MEM_BUS_MMIO_EN
            end else if (is_sw) begin
                rdata_d = DATA_W'(sw_sync_q);
            end else if (is_led) begin
                rdata_d = DATA_W'(led_q);
`endif
            end
        end
    end

    // RAM write port: commits only on the ACCESS edge, so a reset before then drops the store.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && cmd_q == CMD_WRITE && is_ram) begin
            mem_q[ram_idx] <= wdata_q;
        end
    end

    // Access sequencer: latch in IDLE, optional wait, perform in ACCESS, pulse mem_rdy in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            cmd_q   <= CMD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
`ifdef MEM_BUS_MMIO_EN
            led_q   <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // Illegal code 11 is accepted too: it completes normally and returns zero.
                    if (mem_cmd != CMD_NONE) begin
                        cmd_q   <= mem_cmd;
                        addr_q  <= mem_addr;
                        wdata_q <= write_data;
                        if (WAIT_STATES > 0) begin
                            wcnt_q  <= WCNT_INIT;
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == '0) begin
                        state_q <= S_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    rdy_q <= 1'b1;
                    // Writes leave read_data holding the last load result.
                    if (cmd_q != CMD_WRITE) begin
                        rdata_q <= rdata_d;
                    end
`ifdef MEM_BUS_MMIO_EN
                    if (cmd_q == CMD_WRITE && is_led) begin
                        led_q <= wdata_q[7:0];
                    end
`endif
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: two instances (0 and 2 wait states) share one stimulus
// stream; a behavioural memory-map model predicts read data, LED state and pulse timing.
module tb_mem_bus_ctrl;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_READ = 2'b01;
    localparam logic [1:0] C_WR   = 2'b10;
    localparam logic [1:0] C_ILL  = 2'b11;

`ifdef MEM_BUS_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw_in;
    logic [15:0] rd0, rd2;
    logic        rdy0, rdy2;
    logic [7:0]  led0, led2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory map
    logic [15:0] ram_m [256];
    bit          ram_v [256];
    logic [7:0]  led_m;
    logic [15:0] last_rd;
    bit          last_v;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.ADDR_W(9), .DATA_W(16), .RAM_DEPTH(256), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(rd0), .mem_rdy(rdy0), .sw_in(sw_in), .led_out(led0)
    );

    mem_bus_ctrl #(.ADDR_W(9), .DATA_W(16), .RAM_DEPTH(256), .WAIT_STATES(2), .INIT_FILE("")) dut2 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(rd2), .mem_rdy(rdy2), .sw_in(sw_in), .led_out(led2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the memory-map rules to one command; returns expected read_data after completion.
    task automatic model(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                         output bit known, output logic [15:0] exp);
        known = last_v;
        exp   = last_rd;
        if (c == C_WR) begin
            if (a < 9'd256) begin
                ram_m[a[7:0]] = d;
                ram_v[a[7:0]] = 1'b1;
            end else if (MMIO && a == 9'h100) begin
                led_m = d[7:0];
            end
        end else if (c == C_READ) begin
            known = 1'b1;
            exp   = 16'h0000;
            if (a < 9'd256) begin
                known = ram_v[a[7:0]];
                exp   = ram_m[a[7:0]];
            end else if (MMIO && a == 9'h140) begin
                exp = {8'h00, sw_in};
            end else if (MMIO && a == 9'h100) begin
                known = 1'b0;
            end
            last_v  = known;
            last_rd = exp;
        end else if (c == C_ILL) begin
            known   = 1'b1;
            exp     = 16'h0000;
            last_v  = 1'b1;
            last_rd = 16'h0000;
        end
    endtask

    // One command sampled in the current cycle; checks pulse timing on both instances.
    task automatic access(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bit          known;
        logic [15:0] exp;
        model(c, a, d, known, exp);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        tick();
        // Scramble the bus: only the latched values may be used from here on.
        mem_cmd    = C_NONE;
        mem_addr   = 9'($urandom);
        write_data = 16'($urandom);
        for (int i = 1; i <= 6; i++) begin
            chk("rdy_ws0", 32'(rdy0), 32'(c != C_NONE && i == 2));
            chk("rdy_ws2", 32'(rdy2), 32'(c != C_NONE && i == 4));
            if (c != C_NONE && known && i == 2) chk("rdata_ws0", 32'(rd0), 32'(exp));
            if (c != C_NONE && known && i == 4) chk("rdata_ws2", 32'(rd2), 32'(exp));
            tick();
        end
        if (last_v) begin
            chk("hold_ws0", 32'(rd0), 32'(last_rd));
            chk("hold_ws2", 32'(rd2), 32'(last_rd));
        end
        chk("led_ws0", 32'(led0), 32'(led_m));
        chk("led_ws2", 32'(led2), 32'(led_m));
    endtask

    initial begin
        logic [1:0]  c;
        logic [8:0]  a;
        int          r;
        for (int i = 0; i < 256; i++) begin
            ram_v[i] = 1'b0;
            ram_m[i] = 16'h0000;
        end
        led_m      = 8'h00;
        last_rd    = 16'h0000;
        last_v     = 1'b1;
        reset_n    = 1'b0;
        mem_cmd    = C_NONE;
        mem_addr   = '0;
        write_data = '0;
        sw_in      = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_rd0",  32'(rd0),  32'd0);
        chk("rst_led0", 32'(led0), 32'd0);
        chk("rst_rdy2", 32'(rdy2), 32'd0);
        chk("rst_rd2",  32'(rd2),  32'd0);
        chk("rst_led2", 32'(led2), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic write then read
        access(C_WR,   9'h005, 16'hABCD);
        access(C_READ, 9'h005, 16'h0000);

        // MMIO LED write and switch read (switch settles through the synchronizer)
        access(C_WR, 9'h100, 16'h12A5);
        sw_in = 8'h3C;
        repeat (3) tick();
        access(C_READ, 9'h140, 16'h0000);

        // Unmapped read/write, then RAM unchanged
        access(C_READ, 9'h1F0, 16'h0000);
        access(C_WR,   9'h1F0, 16'hFFFF);
        access(C_READ, 9'h005, 16'h0000);

        // Reset in the middle of a write: write lost, no pulse, back to IDLE
        access(C_WR, 9'h010, 16'h2222);
        mem_cmd    = C_WR;
        mem_addr   = 9'h010;
        write_data = 16'h1111;
        tick();
        mem_cmd = C_NONE;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_rdy0", 32'(rdy0), 32'd0);
            chk("midrst_rdy2", 32'(rdy2), 32'd0);
            chk("midrst_led0", 32'(led0), 32'd0);
            tick();
        end
        reset_n = 1'b1;
        led_m   = 8'h00;
        last_rd = 16'h0000;
        last_v  = 1'b1;
        tick();
        access(C_READ, 9'h010, 16'h0000);

        // Illegal command code, LED write (stays 0 without MMIO), switch read
        access(C_ILL,  9'h005, 16'h5555);
        access(C_WR,   9'h100, 16'h00FF);
        access(C_READ, 9'h140, 16'h0000);

        // Back-to-back reads with mem_cmd held
        access(C_WR, 9'h020, 16'hBEEF);
        mem_cmd  = C_READ;
        mem_addr = 9'h020;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 4) mem_cmd = C_NONE;
            chk("b2b_rdy0", 32'(rdy0), 32'(i == 2 || i == 5));
            chk("b2b_rdy2", 32'(rdy2), 32'(i == 4));
            if (i == 2 || i == 5) chk("b2b_rd0", 32'(rd0), 32'h0000BEEF);
            if (i == 4)           chk("b2b_rd2", 32'(rd2), 32'h0000BEEF);
        end
        last_rd = 16'hBEEF;
        last_v  = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                sw_in = 8'($urandom);
                repeat (3) tick();
            end
            r = $urandom_range(0, 9);
            c = (r == 0) ? C_NONE : (r == 1) ? C_ILL : (r < 6) ? C_READ : C_WR;
            r = $urandom_range(0, 7);
            a = (r == 0) ? 9'h100 : (r == 1) ? 9'h140 : (r == 2) ? 9'($urandom) : 9'($urandom_range(0, 31));
            access(c, a, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
